// File: rtl/muldiv_pkg.sv
// Shared encodings and op-class helpers for the multi-cycle M-extension unit.
// Imported by muldiv_unit and muldiv_iter_core.
package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } state_e;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic is_rem(input logic [2:0] op);
        return op[2] && op[1];
    endfunction

    function automatic logic is_signed_a(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_MULH) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Iterative unsigned datapath: shift-add multiply or restoring radix-2 divide.
// Ports: load (a_mag, b_mag, div_mode), step (one iteration), acc (product or {rem, quo}).
module muldiv_iter_core #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic              div_mode,
    input  logic [XLEN-1:0]   a_mag,
    input  logic [XLEN-1:0]   b_mag,
    output logic [2*XLEN-1:0] acc
);

    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic              div_q, div_d;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     trial;

    always_comb begin
        // Multiply: low half holds the remaining multiplier bits; the
        // partial product grows into the high half as it shifts right.
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                  {1'b0, b_q & {XLEN{acc_q[0]}}};
        // Divide: shift {rem, quo} left; the extra bit keeps the trial exact.
        rem_sh  = acc_q[2*XLEN-1:XLEN-1];
        trial   = rem_sh - {1'b0, b_q};

        acc_d = acc_q;
        b_d   = b_q;
        div_d = div_q;

        if (load) begin
            acc_d = {{XLEN{1'b0}}, a_mag};
            b_d   = b_mag;
            div_d = div_mode;
        end else if (step) begin
            if (div_q) begin
                if (!trial[XLEN]) begin
                    acc_d = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                end else begin
                    acc_d = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
                end
            end else begin
                acc_d = {mul_sum, acc_q[XLEN-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            b_q   <= b_d;
            div_q <= div_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M/RV64M multiply/divide unit with valid/ready and flush.
// Ports: in_* request (op, rs1, rs2, tag), out_* result (result, tag), busy, flush.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int              CNT_W   = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [TAG_W-1:0]   otag_q, otag_d;
    logic               a_neg_q, a_neg_d;
    logic               b_neg_q, b_neg_d;
    logic [XLEN-1:0]    res_q, res_d;
    logic               vld_q, vld_d;

    logic               accept;
    logic               a_neg_in, b_neg_in;
    logic [XLEN-1:0]    a_mag, b_mag;
    logic               div_zero, ovf, special;
    logic [XLEN-1:0]    spec_res;

    logic               core_load, core_step;
    logic [2*XLEN-1:0]  acc;
    logic [2*XLEN-1:0]  prod;
    logic [XLEN-1:0]    quo, rem;
    logic [XLEN-1:0]    fix_res;

    assign in_ready   = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign out_valid  = vld_q;
    assign out_result = res_q;
    assign out_tag    = otag_q;

    assign accept = in_valid && in_ready && !flush;

    // Request-side decode: magnitudes and the 1-cycle special cases.
    always_comb begin
        a_neg_in = is_signed_a(in_op) && in_rs1[XLEN-1];
        b_neg_in = is_signed_b(in_op) && in_rs2[XLEN-1];
        a_mag    = a_neg_in ? -in_rs1 : in_rs1;
        b_mag    = b_neg_in ? -in_rs2 : in_rs2;
        div_zero = (in_rs2 == '0);
        ovf      = ((in_op == OP_DIV) || (in_op == OP_REM)) &&
                   (in_rs1 == MIN_NEG) && (in_rs2 == '1);
        special  = is_div(in_op) && (div_zero || ovf);

        spec_res = MIN_NEG;
        unique case (1'b1)
            div_zero &&  is_rem(in_op): spec_res = in_rs1;
            div_zero && !is_rem(in_op): spec_res = '1;
            !div_zero && is_rem(in_op): spec_res = '0;
            default:                    spec_res = MIN_NEG;
        endcase
    end

    assign core_load = accept && !special;
    assign core_step = (state_q == ST_CALC);

    muldiv_iter_core #(
        .XLEN(XLEN)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (core_load),
        .step     (core_step),
        .div_mode (is_div(in_op)),
        .a_mag    (a_mag),
        .b_mag    (b_mag),
        .acc      (acc)
    );

    // Sign fix-up: quotient/product follow the sign xor, remainder the dividend.
    always_comb begin
        prod = (a_neg_q ^ b_neg_q) ? -acc : acc;
        quo  = (a_neg_q ^ b_neg_q) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = a_neg_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

        fix_res = rem;
        unique case (1'b1)
            op_q == OP_MUL:                   fix_res = prod[XLEN-1:0];
            !is_div(op_q) && op_q != OP_MUL:  fix_res = prod[2*XLEN-1:XLEN];
            is_div(op_q) && !is_rem(op_q):    fix_res = quo;
            default:                          fix_res = rem;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        tag_d   = tag_q;
        otag_d  = otag_q;
        a_neg_d = a_neg_q;
        b_neg_d = b_neg_q;
        res_d   = res_q;
        vld_d   = vld_q;

        if (flush) begin
            state_d = ST_IDLE;
            vld_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_d    = in_op;
                        tag_d   = in_tag;
                        a_neg_d = a_neg_in;
                        b_neg_d = b_neg_in;
                        if (special) begin
                            state_d = ST_DONE;
                            vld_d   = 1'b1;
                            res_d   = spec_res;
                            otag_d  = in_tag;
                        end else begin
                            state_d = ST_CALC;
                            cnt_d   = '0;
                        end
                    end
                end
                ST_CALC: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_FIX;
                    end
                end
                ST_FIX: begin
                    state_d = ST_DONE;
                    vld_d   = 1'b1;
                    res_d   = fix_res;
                    otag_d  = tag_q;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                        vld_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    vld_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            tag_q   <= '0;
            otag_q  <= '0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            res_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            tag_q   <= tag_d;
            otag_q  <= otag_d;
            a_neg_q <= a_neg_d;
            b_neg_q <= b_neg_d;
            res_q   <= res_d;
            vld_q   <= vld_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit at XLEN=32.
// Directed vectors, handshake/flush/reset scenarios, and a model-checked random run.
module tb_muldiv_unit;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;
    localparam int NORM  = XLEN + 1;
    localparam int SPEC  = 0;
    localparam logic [31:0] MINV = 32'h8000_0000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       in_op = '0;
    logic [XLEN-1:0]  in_rs1 = '0;
    logic [XLEN-1:0]  in_rs2 = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    muldiv_unit #(
        .XLEN  (XLEN),
        .TAG_W (TAG_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  res;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Monitor: every accepted result is popped and compared.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !flush) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result: got tag %h res %h want none",
                         out_tag, out_result);
            end else begin
                mon_e = sbq.pop_front();
                check("result", {27'b0, out_tag, out_result}, {27'b0, mon_e});
            end
        end
    end

    function automatic logic [31:0] model(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        logic [31:0] r;
        r = '0;
        p = '0;
        case (op)
            3'd0: begin
                p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
                r = p[31:0];
            end
            3'd1: begin
                p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
                r = p[63:32];
            end
            3'd2: begin
                p = {{32{a[31]}}, a} * {32'b0, b};
                r = p[63:32];
            end
            3'd3: begin
                p = {32'b0, a} * {32'b0, b};
                r = p[63:32];
            end
            3'd4: begin
                if (b == 0) r = '1;
                else if (a == MINV && b == '1) r = MINV;
                else r = $signed(a) / $signed(b);
            end
            3'd5: r = (b == 0) ? '1 : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (a == MINV && b == '1) r = '0;
                else r = $signed(a) % $signed(b);
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Called at #1 after a rising edge; returns #1 after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag,
                         input logic [31:0] exp_res, input bit push);
        int guard;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_timeout: got in_ready 0 want 1");
        end
        in_op    = op;
        in_rs1   = a;
        in_rs2   = b;
        in_tag   = tag;
        in_valid = 1'b1;
        if (push) sbq.push_back({tag, exp_res});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_rs1   = ~a;
        in_rs2   = ~b;
        in_tag   = ~tag;
        in_op    = ~op;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!out_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL valid_timeout: got out_valid 0 want 1");
        end
    endtask

    task automatic run(input string name, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] exp_res,
                       input int lat);
        int n;
        issue(op, a, b, tag, exp_res, 1'b1);
        wait_valid(n);
        check(name, 64'(n), 64'(lat));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   n;
        bit   seen;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        #1;
        check("reset_outputs", {62'b0, out_valid, busy}, 64'd0);
        check("reset_data", {27'b0, out_tag, out_result}, 64'd0);
        #20;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_ready", {62'b0, in_ready, busy}, 64'b10);

        run("lat_mul",    3'b000, 32'd7,        32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, NORM);
        run("lat_mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, NORM);
        run("lat_mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, NORM);
        run("lat_mulh",   3'b001, MINV,          MINV,          5'd4, 32'h4000_0000, NORM);
        run("lat_div_ov", 3'b100, MINV,          32'hFFFF_FFFF, 5'd5, MINV,          SPEC);
        run("lat_rem_ov", 3'b110, MINV,          32'hFFFF_FFFF, 5'd6, 32'd0,         SPEC);
        run("lat_divu",   3'b101, MINV,          32'hFFFF_FFFF, 5'd7, 32'd0,         NORM);
        run("lat_divu_z", 3'b101, 32'd123,       32'd0,         5'd8, 32'hFFFF_FFFF, SPEC);
        run("lat_rem_z",  3'b110, 32'd123,       32'd0,         5'd9, 32'd123,       SPEC);
        run("lat_rem_n",  3'b110, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFF, NORM);
        run("lat_div_n",  3'b100, 32'hFFFF_FFF9, 32'd2,         5'd11, 32'hFFFF_FFFD, NORM);
        run("lat_div_nd", 3'b100, 32'd100,       32'hFFFF_FFF9, 5'd12, 32'hFFFF_FFF2, NORM);
        run("lat_remu",   3'b111, 32'd100,       32'd7,         5'd13, 32'd2,        NORM);
        run("lat_mul_mx", 3'b000, 32'h0001_0001, 32'h0001_0001, 5'd14, 32'h0002_0001, NORM);

        // Backpressure: hold the result for five cycles.
        out_ready = 1'b0;
        issue(3'b000, 32'd1000, 32'd1000, 5'd15, 32'd1_000_000, 1'b1);
        wait_valid(n);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", {29'b0, out_valid, in_ready, busy, out_result},
                  {29'b0, 1'b1, 1'b0, 1'b1, 32'd1_000_000});
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_ready", {63'b0, in_ready}, 64'd1);
        run("bp_next", 3'b011, 32'd6, 32'd7, 5'd16, 32'd0, NORM);

        // Flush mid-divide.
        issue(3'b100, 32'd1000, 32'd3, 5'd17, 32'd0, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_calc", {61'b0, in_ready, busy, out_valid}, 64'b100);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("flush_no_valid", {63'b0, seen}, 64'd0);
        run("post_flush_mul", 3'b000, 32'd3, 32'd4, 5'd18, 32'd12, NORM);

        // Flush in DONE with out_ready high discards the result.
        out_ready = 1'b0;
        issue(3'b000, 32'd5, 32'd5, 5'd19, 32'd25, 1'b0);
        wait_valid(n);
        flush = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_done", {62'b0, out_valid, in_ready}, 64'b01);

        // A request coinciding with flush is ignored.
        in_op = 3'b000;
        in_rs1 = 32'd2;
        in_rs2 = 32'd2;
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush = 1'b0;
        check("flush_blocks_accept", {63'b0, busy}, 64'd0);

        // Asynchronous reset mid-calculation.
        issue(3'b100, 32'd1000, 32'd3, 5'd20, 32'd0, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {25'b0, out_valid, busy, out_tag, out_result},
              64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release", {62'b0, in_ready, busy}, 64'b10);

        // Randomised ops against the reference model.
        for (int i = 0; i < 300; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 9))
                0: rb = '0;
                1: begin ra = MINV; rb = '1; end
                2: rb = 32'($urandom_range(1, 9));
                3: ra = 32'($urandom_range(0, 50));
                default: ;
            endcase
            issue(rop, ra, rb, 5'(i), model(rop, ra, rb), 1'b1);
            wait_valid(n);
            @(posedge clk);
            #1;
        end

        repeat (5) @(posedge clk);
        check("queue_drain", 64'(sbq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
